// File: rtl/bus_responder.sv
// bus_responder
//   Slave end of the CPU master bus. Accepts one read or write per handshake,
//   inserts programmable wait states, services one on-chip RAM region (IWRAM)
//   with byte-enable writes and lane-aligned reads, and returns the GBA
//   open-bus value for unmapped reads.
//
// Ports
//   clk               clock
//   reset             synchronous, active-high
//   addr[31:0]        byte address, held by the master until ready
//   wdata[31:0]       write data, low-lane justified
//   size[1:0]         00 byte, 01 halfword, 10/11 word
//   read_en           read request
//   write_en          write request (both enables high -> read + fault)
//   instruction_fetch qualifies a read as an opcode fetch (feeds open bus)
//   rdata[31:0]       read data, valid with ready, held until next completion
//   ready             single-cycle completion pulse
//   fault             pulses with ready for unmapped or illegal requests
//
// Build option
//   GBA_BUS_SEQ_EN    when defined, a read at last_addr+4 issued in the idle
//                     cycle right after a completed read uses S_WAIT instead
//                     of N_WAIT.

module bus_responder #(
  parameter int unsigned MEM_WORDS = 8192,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned N_WAIT    = 2,
  parameter int unsigned S_WAIT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        read_en,
  input  logic        write_en,
  input  logic        instruction_fetch,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        fault
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  N_WAIT_C  = 4'(N_WAIT);
  localparam logic [3:0]  S_WAIT_C  = 4'(S_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [1:0]  req_size_q, req_size_d;
  logic        req_read_q, req_read_d;
  logic        req_write_q, req_write_d;
  logic        req_fetch_q, req_fetch_d;
  logic        req_illegal_q, req_illegal_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic [31:0] open_bus_q, open_bus_d;
  logic [31:0] rdata_hold_q, rdata_hold_d;

  logic        req;
  logic        seq_hit;
  logic [3:0]  wait_sel;
  logic [31:0] ram_off;
  logic        ram_hit;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram_rd_q;
  logic [31:0] rd_fmt;
  logic [31:0] rdata_done;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_word;

  logic [31:0] mem [MEM_WORDS];

  function automatic logic [31:0] rotr(input logic [31:0] w, input logic [4:0] sh);
    logic [63:0] t;
    t = {w, w} >> sh;
    return t[31:0];
  endfunction

  assign req = read_en | write_en;

  // The address is captured on a request in IDLE. req_addr_d is the address
  // the access will use, so during the cycle that enters DONE it is already
  // the latched address; the RAM is addressed from it so the synchronous read
  // lands in DONE.
  assign req_addr_d = (state_q == IDLE && req) ? addr : req_addr_q;
  assign ram_off    = req_addr_d - BASE_ADDR;
  assign ram_hit    = ram_off < MEM_BYTES;
  assign ram_idx    = ram_off[AW+1:2];

  assign wait_sel = seq_hit ? S_WAIT_C : N_WAIT_C;

  // Read lane alignment: bytes and halfwords are rotated down to lane 0;
  // word (and misaligned halfword) rotates are left to the master.
  always_comb begin
    case (req_size_q)
      2'b00:   rd_fmt = rotr(ram_rd_q, {req_addr_q[1:0], 3'b000});
      2'b01:   rd_fmt = rotr(ram_rd_q, {req_addr_q[1], 4'b0000});
      default: rd_fmt = ram_rd_q;
    endcase
  end

  // In DONE, ram_hit reflects the latched address.
  assign rdata_done = ram_hit ? rd_fmt : open_bus_q;

  // Write lane steering with byte enables.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (req_size_q)
          2'b00: begin
            wr_be[gi]           = (req_addr_q[1:0] == 2'(gi));
            wr_word[gi*8 +: 8]  = req_wdata_q[7:0];
          end
          2'b01: begin
            wr_be[gi]           = (req_addr_q[1] == 1'(gi / 2));
            wr_word[gi*8 +: 8]  = req_wdata_q[(gi % 2)*8 +: 8];
          end
          default: begin
            wr_be[gi]           = 1'b1;
            wr_word[gi*8 +: 8]  = req_wdata_q[gi*8 +: 8];
          end
        endcase
      end
    end
  endgenerate

  // Write commits on the edge leaving DONE; a reset on that edge suppresses it.
  assign wr_en = (state_q == DONE) && req_write_q && ram_hit && !reset;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[ram_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
    ram_rd_q <= mem[ram_idx];
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    req_wdata_d   = req_wdata_q;
    req_size_d    = req_size_q;
    req_read_d    = req_read_q;
    req_write_d   = req_write_q;
    req_fetch_d   = req_fetch_q;
    req_illegal_d = req_illegal_q;
    ready_d       = 1'b0;
    fault_d       = 1'b0;
    open_bus_d    = open_bus_q;
    rdata_hold_d  = rdata_hold_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          req_wdata_d   = wdata;
          req_size_d    = size;
          req_read_d    = read_en;
          req_write_d   = write_en & ~read_en;
          req_fetch_d   = instruction_fetch;
          req_illegal_d = read_en & write_en;
          if (wait_sel == 4'd0) begin
            state_d = DONE;
            ready_d = 1'b1;
            fault_d = ~ram_hit | (read_en & write_en);
          end else begin
            state_d = WAIT;
            wcnt_d  = wait_sel - 4'd1;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          fault_d = ~ram_hit | req_illegal_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (req_read_q) begin
          rdata_hold_d = rdata_done;
          if (ram_hit && req_fetch_q) begin
            open_bus_d = rdata_done;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wcnt_q        <= 4'd0;
      req_addr_q    <= 32'd0;
      req_wdata_q   <= 32'd0;
      req_size_q    <= 2'd0;
      req_read_q    <= 1'b0;
      req_write_q   <= 1'b0;
      req_fetch_q   <= 1'b0;
      req_illegal_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
      open_bus_q    <= 32'd0;
      rdata_hold_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      req_size_q    <= req_size_d;
      req_read_q    <= req_read_d;
      req_write_q   <= req_write_d;
      req_fetch_q   <= req_fetch_d;
      req_illegal_q <= req_illegal_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
      open_bus_q    <= open_bus_d;
      rdata_hold_q  <= rdata_hold_d;
    end
  end

`ifdef GBA_BUS_SEQ_EN
  logic [31:0] last_addr_q, last_addr_d;
  logic        seq_ok_q, seq_ok_d;

  // seq_ok can only be set while in IDLE if the previous cycle was DONE,
  // since any idle cycle without a request clears it.
  assign seq_hit = seq_ok_q && read_en && (addr == last_addr_q + 32'd4);

  always_comb begin
    last_addr_d = last_addr_q;
    seq_ok_d    = seq_ok_q;
    if (state_q == IDLE && !req) begin
      last_addr_d = 32'd0;
      seq_ok_d    = 1'b0;
    end else if (state_q == DONE) begin
      last_addr_d = req_addr_q;
      seq_ok_d    = req_read_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr_q <= 32'd0;
      seq_ok_q    <= 1'b0;
    end else begin
      last_addr_q <= last_addr_d;
      seq_ok_q    <= seq_ok_d;
    end
  end
`else
  assign seq_hit = 1'b0;
`endif

  // rdata comes straight from the formatted RAM word during a read's DONE
  // cycle (the RAM output register is the pipeline stage), otherwise from
  // the held copy of the last completed read.
  assign rdata = (state_q == DONE && req_read_q) ? rdata_done : rdata_hold_q;
  assign ready = ready_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        read_en;
  logic        write_en;
  logic        instruction_fetch;
  logic [31:0] rdata;
  logic        ready;
  logic        fault;

  localparam int LAT_N = 3;
`ifdef GBA_BUS_SEQ_EN
  localparam int LAT_S = 2;
`else
  localparam int LAT_S = 3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bus_responder dut (
    .clk               (clk),
    .reset             (reset),
    .addr              (addr),
    .wdata             (wdata),
    .size              (size),
    .read_en           (read_en),
    .write_en          (write_en),
    .instruction_fetch (instruction_fetch),
    .rdata             (rdata),
    .ready             (ready),
    .fault             (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic fch,
                        input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                        input int exp_lat, output logic [31:0] got, output logic flt);
    int lat;
    @(posedge clk); #1;
    addr = a; wdata = wd; size = sz;
    read_en = rd; write_en = wr; instruction_fetch = fch;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 40);
    got = rdata;
    flt = fault;
    check({tag, "/ready"}, 32'(ready), 32'd1);
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    read_en = 1'b0; write_en = 1'b0; instruction_fetch = 1'b0;
    $display("txn %-14s rd=%b wr=%b addr=%08h size=%0d wdata=%08h lat=%0d rdata=%08h fault=%b",
             tag, rd, wr, a, sz, wd, lat, got, flt);
  endtask

  task automatic do_wr(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, input logic exp_fault);
    logic [31:0] got;
    logic        flt;
    access(tag, 1'b0, 1'b1, 1'b0, a, sz, d, LAT_N, got, flt);
    check({tag, "/fault"}, 32'(flt), 32'(exp_fault));
  endtask

  task automatic do_rd(input string tag, input logic [31:0] a, input logic [1:0] sz,
                       input logic fch, input logic [31:0] exp_data, input logic exp_fault,
                       input int exp_lat);
    logic [31:0] got;
    logic        flt;
    access(tag, 1'b1, 1'b0, fch, a, sz, 32'd0, exp_lat, got, flt);
    check({tag, "/rdata"}, got, exp_data);
    check({tag, "/fault"}, 32'(flt), 32'(exp_fault));
  endtask

  initial begin
    logic [31:0] got;
    logic        flt;
    logic        seen;
    int          n;

    reset = 1'b1; addr = 32'd0; wdata = 32'd0; size = 2'd0;
    read_en = 1'b0; write_en = 1'b0; instruction_fetch = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/ready", 32'(ready), 32'd0);
    check("reset/fault", 32'(fault), 32'd0);
    check("reset/rdata", rdata, 32'd0);
    reset = 1'b0;

    // word write then read
    do_wr("wr_word", 32'h0300_0010, 2'b10, 32'hDEAD_BEEF, 1'b0);
    do_rd("rd_word", 32'h0300_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, LAT_N);

    // rdata held after completion
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | ready;
    end
    check("hold/rdata", rdata, 32'hDEAD_BEEF);
    check("hold/no_ready", 32'(seen), 32'd0);

    // byte / halfword lanes
    do_wr("wr_byte12", 32'h0300_0012, 2'b00, 32'h0000_0077, 1'b0);
    do_rd("rd_word_b", 32'h0300_0010, 2'b10, 1'b0, 32'hDE77_BEEF, 1'b0, LAT_N);
    do_rd("rd_byte13", 32'h0300_0013, 2'b00, 1'b0, 32'h77BE_EFDE, 1'b0, LAT_N);
    do_rd("rd_half12", 32'h0300_0012, 2'b01, 1'b0, 32'hBEEF_DE77, 1'b0, LAT_N);
    do_wr("wr_half11", 32'h0300_0011, 2'b01, 32'hFFFF_1234, 1'b0);
    do_rd("rd_word_h", 32'h0300_0010, 2'b10, 1'b0, 32'hDE77_1234, 1'b0, LAT_N);
    do_rd("rd_byte11", 32'h0300_0011, 2'b00, 1'b0, 32'h34DE_7712, 1'b0, LAT_N);

    // open bus
    do_rd("fetch10", 32'h0300_0010, 2'b10, 1'b1, 32'hDE77_1234, 1'b0, LAT_N);
    do_rd("rd_unmap", 32'h0800_0000, 2'b10, 1'b0, 32'hDE77_1234, 1'b1, LAT_N);
    do_wr("wr_unmap", 32'h0200_0010, 2'b10, 32'h0000_0000, 1'b1);
    do_rd("rd_after_um", 32'h0300_0010, 2'b10, 1'b0, 32'hDE77_1234, 1'b0, LAT_N);

    // both enables: executed as read with fault, no write
    access("both_en", 1'b1, 1'b1, 1'b0, 32'h0300_0010, 2'b10, 32'hFFFF_FFFF, LAT_N, got, flt);
    check("both_en/rdata", got, 32'hDE77_1234);
    check("both_en/fault", 32'(flt), 32'd1);
    do_rd("rd_after_both", 32'h0300_0010, 2'b10, 1'b0, 32'hDE77_1234, 1'b0, LAT_N);

    // region edges
    do_wr("wr_last", 32'h0300_7FFC, 2'b10, 32'hCAFE_F00D, 1'b0);
    do_rd("rd_past_end", 32'h0300_8000, 2'b10, 1'b0, 32'hDE77_1234, 1'b1, LAT_N);
    do_rd("rd_last", 32'h0300_7FFC, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, LAT_N);

    // reset during WAIT of a write
    do_wr("wr_20", 32'h0300_0020, 2'b10, 32'h1122_3344, 1'b0);
    @(posedge clk); #1;
    addr = 32'h0300_0020; wdata = 32'hAAAA_AAAA; size = 2'b10; write_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; write_en = 1'b0;
    @(posedge clk); #1;
    check("rst_wait/ready", 32'(ready), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | ready;
    end
    check("rst_wait/no_ready", 32'(seen), 32'd0);
    $display("txn %-14s reset asserted in WAIT", "rst_wait");
    do_rd("rd_ob_clr", 32'h0800_0000, 2'b10, 1'b0, 32'h0000_0000, 1'b1, LAT_N);
    do_rd("rd_20_a", 32'h0300_0020, 2'b10, 1'b0, 32'h1122_3344, 1'b0, LAT_N);

    // reset coinciding with the DONE edge of a write
    @(posedge clk); #1;
    addr = 32'h0300_0020; wdata = 32'h5555_5555; size = 2'b10; write_en = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready && n < 40);
    check("rst_done/ready", 32'(ready), 32'd1);
    reset = 1'b1; write_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_done/ready_low", 32'(ready), 32'd0);
    $display("txn %-14s reset asserted on DONE edge", "rst_done");
    do_rd("rd_20_b", 32'h0300_0020, 2'b10, 1'b0, 32'h1122_3344, 1'b0, LAT_N);

    // sequential timing
    access("seq_a", 1'b1, 1'b0, 1'b0, 32'h0300_0000, 2'b10, 32'd0, LAT_N, got, flt);
    access("seq_b", 1'b1, 1'b0, 1'b0, 32'h0300_0004, 2'b10, 32'd0, LAT_S, got, flt);
    repeat (2) @(posedge clk);
    access("seq_gap", 1'b1, 1'b0, 1'b0, 32'h0300_0008, 2'b10, 32'd0, LAT_N, got, flt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
# bus_responder

Memory-side responder for the CPU's master bus port. Accepts one read or write per handshake, inserts programmable wait states, services a single on-chip RAM region (IWRAM), returns lane-aligned read data, and returns GBA open-bus values for unmapped reads. Sits between the CPU bus master and the on-chip RAM array and is the slave end of the same address/data/enable protocol.

## Interface
- `MEM_WORDS`, default 8192: RAM depth in 32-bit words (32 KiB); must be a power of two.
- `BASE_ADDR`, default 32'h0300_0000: byte address of word 0; aligned to MEM_WORDS*4.
- `N_WAIT`, default 2: non-sequential wait states, range 0-15.
- `S_WAIT`, default 1: sequential wait states, range 0-15; used only with GBA_BUS_SEQ_EN.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `addr`  in  32  byte address, held by the master until `ready`.
- `wdata`  in  32  write data, low-lane justified.
- `size`  in  2  transfer size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `read_en`  in  1  read request.
- `write_en`  in  1  write request.
- `instruction_fetch`  in  1  qualifies a read as an opcode fetch.
- `rdata`  out  32  read data; valid in the cycle `ready`=1 and held until the next completion.
- `ready`  out  1  single-cycle completion pulse.
- `fault`  out  1  pulses with `ready` for an unmapped access or an illegal request.

## Operation
- FSM states:
  - IDLE: no request in flight.
  - WAIT: wait-state counter `wcnt` (4 bits) decrements each cycle.
  - DONE: access performed; `ready`=1.
- Transitions:
  - IDLE → WAIT when (`read_en`|`write_en`) and the selected wait count is >0. Latch `addr`, `wdata`, `size`, direction and fetch into request registers. Load `wcnt` with wait−1.
  - IDLE → DONE directly when the selected wait count is 0.
  - WAIT → DONE when `wcnt`==0.
  - DONE → IDLE unconditionally.
- Mapped test: (`addr` − `BASE_ADDR`) < MEM_WORDS*4, evaluated on the latched address. Word index is offset[log2(MEM_WORDS)+1:2].
- Read data, formed from the aligned RAM word W:
  - byte: W rotated right by addr[1:0]*8, so the addressed byte is at [7:0].
  - halfword: W rotated right by addr[1]*16. addr[0] is not acted on here; the master applies the misaligned rotate.
  - word: W unrotated. The master applies the misaligned rotate.
- Write data:
  - byte: `wdata`[7:0] goes to lane addr[1:0].
  - halfword: `wdata`[15:0] goes to lane addr[1]; addr[0] is ignored.
  - word: the full word is written; addr[1:0] are ignored.
  - Other lanes are unchanged (byte-enable write).
- Open bus:
  - 32-bit `open_bus` register, reset 0.
  - Updated with the returned word on every mapped read that has `instruction_fetch`=1.
  - Unmapped reads return `open_bus` and pulse `fault`.
  - Unmapped writes are dropped and pulse `fault`.
- `read_en` and `write_en` both high: executed as a read, `fault`=1 at completion.
- Requests arriving while not in IDLE are ignored; inputs are sampled only in IDLE.

## Timing
- Reset values: `rdata`=0, `ready`=0, `fault`=0, state IDLE, `open_bus`=0. RAM contents are not cleared.
- Latency: request sampled in IDLE at cycle T gives `ready` at T+W+1, where W is the selected wait count. W=0 gives `ready` at T+1.
- The master must drop or replace its enables in the `ready` cycle. An enable still high in the IDLE cycle after DONE is a new request.
- Back-to-back throughput: one transfer per W+2 cycles.
- RAM read is synchronous. Its address is presented on the DONE-entry cycle so that `rdata` is registered in DONE.
- A write commits at the DONE clock edge. A read of the same address sampled in the following IDLE sees the new data.
- `reset` asserted mid-transfer:
  - returns to IDLE next edge, `ready`=0;
  - no write commits if reset coincides with the DONE edge;
  - `open_bus` clears.

## Configuration
- `GBA_BUS_SEQ_EN` defined:
  - A `last_addr` register and a `seq_ok` flag are kept.
  - A read request sampled in the IDLE cycle immediately after DONE, with `addr`==`last_addr`+4 and the previous access also a read, uses `S_WAIT`.
  - All other requests use `N_WAIT`.
  - `last_addr` and `seq_ok` clear on reset and on any idle cycle without a request.
- `GBA_BUS_SEQ_EN` undefined: every access uses `N_WAIT`; `last_addr` and `seq_ok` are absent.

## Test plan
- Word write 0xDEADBEEF to 0x03000010 (size 10), then word read → `ready` 3 cycles after the sample (N_WAIT=2), `rdata`=0xDEADBEEF, `fault`=0.
- Byte write 0x77 to 0x03000012, then word read → 0xDE77BEEF. Byte read of 0x03000013 → `rdata`[7:0]=0xDE.
- Halfword read of 0x03000012 → `rdata`[15:0]=0xDE77. Halfword write 0x1234 to 0x03000011 → word becomes 0xDE771234.
- Fetch read of 0x03000010 (open_bus←0xDE771234), then read of 0x08000000 → `rdata`=0xDE771234, `fault`=1. Write to 0x02000000 → RAM unchanged, `fault`=1.
- Assert `reset` in WAIT of a write to 0x03000020 → no `ready`, word at 0x03000020 unchanged, `open_bus`=0.
- With `GBA_BUS_SEQ_EN`: back-to-back reads of 0x03000000 then 0x03000004 → second `ready` 2 cycles after its sample. Without the macro → 3 cycles.
